// File: rtl/sd_sector_writer.sv
// sd_sector_writer: buffers an input byte stream in a FIFO and emits it as LBA-addressed sector writes.
// Optional ack watchdog with sticky ERR: define SD_SECTOR_WRITER_TIMEOUT_EN.
module sd_sector_writer #(
  parameter int unsigned SECTOR_BYTES   = 512,
  parameter int unsigned FIFO_DEPTH     = 1024,
  parameter logic [31:0] START_LBA      = 32'd0,
  parameter logic [7:0]  PAD_BYTE       = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLOCK50,
  input  logic        RESET,
  input  logic        IN_VALID,
  input  logic [7:0]  IN_DATA,
  output logic        IN_READY,
  input  logic        FLUSH,
  output logic        WR_STB,
  output logic [31:0] WR_ADDR,
  input  logic        WR_ACK,
  output logic        WD_STB,
  output logic [7:0]  WD_DATA,
  input  logic        WD_ACK,
  output logic        BUSY,
  output logic [31:0] SECTOR_CNT,
  output logic        ERR
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(SECTOR_BYTES) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] SECTOR_C = CW'(SECTOR_BYTES);
  localparam logic [SW-1:0] SECTOR_S = SW'(SECTOR_BYTES);

  if (((SECTOR_BYTES & (SECTOR_BYTES - 1)) != 0) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (FIFO_DEPTH < SECTOR_BYTES) || (TIMEOUT_CYCLES == 0)) begin : g_bad_params
    $error("sd_sector_writer: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] real_left_q, real_left_d, bytes_left_q, bytes_left_d;
  logic [31:0]   lba_q, lba_d, sector_cnt_q, sector_cnt_d;
  logic [7:0]    wd_data_q, wd_data_d;
  logic          flush_pend_q, flush_pend_d;
  logic          wr_stb_q, wr_stb_d, wd_stb_q, wd_stb_d;
  logic          in_ready, push, pop, start, wr_ack_ok, wd_ack_ok, timeout;

  assign in_ready  = count_q < DEPTH_C;
  assign push      = IN_VALID && in_ready;
  assign wr_ack_ok = (state_q == S_CMD) && wr_stb_q && WR_ACK;
  assign wd_ack_ok = (state_q == S_DATA) && wd_stb_q && WD_ACK;
  assign pop       = wd_ack_ok && (real_left_q != '0);
  assign start     = (state_q == S_IDLE) &&
                     ((count_q >= SECTOR_C) || (flush_pend_q && (count_q != '0)));

  // NOTE: storage carries no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge CLOCK50) begin
    if (push) mem_q[wr_ptr_q] <= IN_DATA;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CMD;
      S_CMD:   if (wr_ack_ok) state_d = S_DATA;
      S_DATA:  if (wd_ack_ok && (bytes_left_q == SW'(1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  always_comb begin
    real_left_d  = real_left_q;
    bytes_left_d = bytes_left_q;
    lba_d        = lba_q;
    sector_cnt_d = sector_cnt_q;
    wd_data_d    = wd_data_q;
    flush_pend_d = flush_pend_q;
    // Strobes come up one cycle after the state they belong to, and drop on the edge that sees the ack.
    wr_stb_d = (state_q == S_CMD) && !wr_ack_ok && !timeout;
    wd_stb_d = (state_q == S_DATA) && !wd_ack_ok && !timeout;

    if (start) begin
      real_left_d  = (count_q >= SECTOR_C) ? SECTOR_S : SW'(count_q);
      bytes_left_d = SECTOR_S;
    end
    if (start && (count_q <= SECTOR_C)) flush_pend_d = 1'b0;
    else if ((state_q == S_IDLE) && (count_q == '0)) flush_pend_d = 1'b0;
    if (FLUSH) flush_pend_d = 1'b1;

    if (wd_ack_ok) begin
      bytes_left_d = bytes_left_q - SW'(1);
      if (real_left_q != '0) real_left_d = real_left_q - SW'(1);
    end
    // Padding is chosen from the sector's own real-byte budget, never from live FIFO occupancy.
    if (wd_stb_d && !wd_stb_q) wd_data_d = (real_left_q != '0) ? mem_q[rd_ptr_q] : PAD_BYTE;

    if (state_q == S_DONE) begin
      lba_d        = lba_q + 32'd1;
      sector_cnt_d = sector_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      real_left_q  <= '0;
      bytes_left_q <= '0;
      lba_q        <= START_LBA;
      sector_cnt_q <= '0;
      wd_data_q    <= '0;
      flush_pend_q <= 1'b0;
      wr_stb_q     <= 1'b0;
      wd_stb_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      real_left_q  <= real_left_d;
      bytes_left_q <= bytes_left_d;
      lba_q        <= lba_d;
      sector_cnt_q <= sector_cnt_d;
      wd_data_q    <= wd_data_d;
      flush_pend_q <= flush_pend_d;
      wr_stb_q     <= wr_stb_d;
      wd_stb_q     <= wd_stb_d;
    end
  end

`ifdef SD_SECTOR_WRITER_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        err_q, err_d;

  assign timeout = (wr_stb_q || wd_stb_q) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    err_d  = err_q || timeout;
    wdog_d = wdog_q;
    if ((state_d != state_q) || wr_ack_ok || wd_ack_ok) wdog_d = '0;
    else if (wr_stb_q || wd_stb_q)                      wdog_d = wdog_q + 32'd1;
  end

  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  assign IN_READY   = in_ready;
  assign WR_STB     = wr_stb_q;
  assign WR_ADDR    = lba_q;
  assign WD_STB     = wd_stb_q;
  assign WD_DATA    = wd_data_q;
  assign BUSY       = (state_q != S_IDLE);
  assign SECTOR_CNT = sector_cnt_q;
endmodule

// File: tb/tb_sd_sector_writer.sv
// tb_sd_sector_writer: directed + randomized bench for sd_sector_writer against a queue-based sector model.
module tb_sd_sector_writer;
  localparam int          SB    = 512;
  localparam int          DEPTH = 1024;
  localparam int          TO    = 50;
  localparam logic [7:0]  PAD   = 8'h00;

  logic        CLOCK50 = 1'b0, RESET = 1'b0, IN_VALID = 1'b0, FLUSH = 1'b0;
  logic        WR_ACK = 1'b0, WD_ACK = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_READY, WR_STB, WD_STB, BUSY, ERR;
  logic [31:0] WR_ADDR, SECTOR_CNT;
  logic [7:0]  WD_DATA;

  sd_sector_writer #(.SECTOR_BYTES(SB), .FIFO_DEPTH(DEPTH), .START_LBA(32'd0),
                     .PAD_BYTE(PAD), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK50(CLOCK50), .RESET(RESET), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .FLUSH(FLUSH), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR),
    .WR_ACK(WR_ACK), .WD_STB(WD_STB), .WD_DATA(WD_DATA), .WD_ACK(WD_ACK),
    .BUSY(BUSY), .SECTOR_CNT(SECTOR_CNT), .ERR(ERR));

  always #5 CLOCK50 = ~CLOCK50;

  int          vectors = 0, miscompares = 0;
  logic [7:0]  model_q[$];
  logic [31:0] model_lba = 0, model_cnt = 0;
  logic [7:0]  cap_data[$];
  logic [31:0] cap_addr[$];
  int          wr_delay = 3, wd_delay = 2;
  bit          stall_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK50);
    #1;
  endtask

  // Card-side responder: acks a strobe once it has been seen high for the configured number of samples.
  initial begin : card
    int wr_n = 0, wd_n = 0;
    forever begin
      @(posedge CLOCK50);
      #1;
      WR_ACK = 1'b0;
      WD_ACK = 1'b0;
      if (WR_STB && !stall_wr) begin
        wr_n++;
        if (wr_n >= wr_delay) begin WR_ACK = 1'b1; cap_addr.push_back(WR_ADDR); wr_n = 0; end
      end else wr_n = 0;
      if (WD_STB) begin
        wd_n++;
        if (wd_n >= wd_delay) begin WD_ACK = 1'b1; cap_data.push_back(WD_DATA); wd_n = 0; end
      end else wd_n = 0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    logic exp_ready;
    exp_ready = (model_q.size() < DEPTH);
    IN_VALID = 1'b1;
    IN_DATA  = b;
    check("in_ready", 32'(IN_READY), 32'(exp_ready));
    step(1);
    IN_VALID = 1'b0;
    if (exp_ready) model_q.push_back(b);
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    step(1);
    FLUSH = 1'b0;
  endtask

  task automatic wait_cnt(input logic [31:0] target, input int budget);
    int t = 0;
    while ((SECTOR_CNT !== target) && (t < budget)) begin step(1); t++; end
    check("sector_done_wait", SECTOR_CNT, target);
  endtask

  // Each sector carries the oldest min(queued, SB) accepted bytes, then PAD up to SB.
  task automatic check_sectors(input int n);
    int real_n, idx;
    logic [7:0]  e, o;
    logic [31:0] a;
    check("cap_addr_count", cap_addr.size(), n);
    check("cap_byte_count", cap_data.size(), n * SB);
    for (int k = 0; k < n; k++) begin
      a = (k < cap_addr.size()) ? cap_addr[k] : 'x;
      check("wr_addr", a, model_lba);
      real_n = (model_q.size() < SB) ? model_q.size() : SB;
      for (int i = 0; i < SB; i++) begin
        e   = (i < real_n) ? model_q.pop_front() : PAD;
        idx = k * SB + i;
        o   = (idx < cap_data.size()) ? cap_data[idx] : 'x;
        check("wd_data", 32'(o), 32'(e));
      end
      model_lba++;
      model_cnt++;
    end
    check("sector_cnt", SECTOR_CNT, model_cnt);
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_stb"}, 32'(WR_STB), 0);
    check({tag, "_wd_stb"}, 32'(WD_STB), 0);
    check({tag, "_wr_addr"}, WR_ADDR, 0);
    check({tag, "_wd_data"}, 32'(WD_DATA), 0);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_sector_cnt"}, SECTOR_CNT, 0);
    check({tag, "_err"}, 32'(ERR), 0);
    check({tag, "_in_ready"}, 32'(IN_READY), 1);
  endtask

  initial begin : guard
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    int t, n, nsec;
    bit saw;

    // Reset state
    step(2);
    check_reset_outputs("reset");
    RESET = 1'b1;
    step(2);

    // Full sector i&FF, with launch latency, then a random second sector at the next LBA
    for (int i = 0; i < SB - 1; i++) push_byte(8'(i));
    push_byte(8'(SB - 1));
    check("lat_e0_wr_stb", 32'(WR_STB), 0);
    step(1);
    check("lat_e1_busy", 32'(BUSY), 1);
    check("lat_e1_wr_stb", 32'(WR_STB), 0);
    step(1);
    check("lat_e2_wr_stb", 32'(WR_STB), 1);
    check("lat_e2_wr_addr", WR_ADDR, model_lba);
    wait_cnt(model_cnt + 1, 6000);
    check_sectors(1);
    for (int i = 0; i < SB; i++) push_byte(8'($urandom));
    wait_cnt(model_cnt + 1, 6000);
    check_sectors(1);

    // Flushed partial sector
    for (int i = 0; i < 100; i++) push_byte(8'hA5);
    step(10);
    check("partial_no_start", 32'(BUSY), 0);
    pulse_flush();
    wait_cnt(model_cnt + 1, 6000);
    check_sectors(1);

    // Flush on an empty FIFO is consumed without a write
    pulse_flush();
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin step(1); saw |= (WR_STB | BUSY); end
    check("empty_flush_quiet", 32'(saw), 0);
    push_byte(8'h5A);
    step(20);
    check("flush_pend_cleared", 32'(BUSY), 0);
    pulse_flush();
    wait_cnt(model_cnt + 1, 6000);
    check_sectors(1);

    // FIFO full with command ack stalled
    stall_wr = 1'b1;
    for (int i = 0; i < DEPTH + 6; i++) push_byte(8'(i) ^ 8'h3C);
    stall_wr = 1'b0;
    wait_cnt(model_cnt + 2, 12000);
    check_sectors(2);

    // Randomized streams, first one exactly one sector long
    for (int r = 0; r < 3; r++) begin
      wr_delay = $urandom_range(1, 4);
      wd_delay = $urandom_range(1, 3);
      n = (r == 0) ? SB : $urandom_range(1, 900);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step(1);
        push_byte(8'($urandom));
      end
      pulse_flush();
      nsec = (n + SB - 1) / SB;
      wait_cnt(model_cnt + nsec, 6000 * nsec);
      check_sectors(nsec);
      step(50);
      check("rand_idle_after", 32'(BUSY), 0);
      check("rand_no_extra_sector", SECTOR_CNT, model_cnt);
    end
    wr_delay = 3;
    wd_delay = 2;

    // Asynchronous reset in the middle of the data phase
    for (int i = 0; i < SB; i++) push_byte(8'($urandom));
    t = 0;
    while ((cap_data.size() < 10) && (t < 6000)) begin step(1); t++; end
    check("midsector_reached", 32'(cap_data.size() >= 10), 1);
    #1;
    RESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step(2);
    RESET = 1'b1;
    step(1);
    model_q.delete();
    model_lba = 0;
    model_cnt = 0;
    cap_addr.delete();
    cap_data.delete();
    for (int i = 0; i < SB; i++) push_byte(8'($urandom));
    wait_cnt(model_cnt + 1, 6000);
    check_sectors(1);

    // Command ack that never comes
    stall_wr = 1'b1;
    for (int i = 0; i < SB; i++) push_byte(8'($urandom));
`ifdef SD_SECTOR_WRITER_TIMEOUT_EN
    t = 0;
    while (!WR_STB && (t < 20)) begin step(1); t++; end
    check("to_stb_rise", 32'(WR_STB), 1);
    step(TO - 1);
    check("to_stb_before_limit", 32'(WR_STB), 1);
    check("to_err_before_limit", 32'(ERR), 0);
    step(1);
    check("to_stb_dropped", 32'(WR_STB), 0);
    check("to_err_set", 32'(ERR), 1);
    check("to_lba_kept", WR_ADDR, model_lba);
    check("to_cnt_kept", SECTOR_CNT, model_cnt);
    stall_wr = 1'b0;
    wait_cnt(model_cnt + 1, 6000);
    check_sectors(1);
    check("to_err_sticky", 32'(ERR), 1);
`else
    step(TO + 10);
    check("nowdog_stb_held", 32'(WR_STB), 1);
    check("nowdog_err", 32'(ERR), 0);
    stall_wr = 1'b0;
    wait_cnt(model_cnt + 1, 6000);
    check_sectors(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
